// File: rtl/fila_pkg.sv
// Shared types and default sizing for the deserializer byte queue.
package fila_pkg;

  localparam int FILA_DEPTH = 8;
  localparam int FILA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } fila_state_t;

endpackage

// File: rtl/fila_mem.sv
// Byte storage for the queue: one write port, one registered read port.
// The read register is the queue's data_out, so it is cleared on reset.
module fila_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read: old contents are returned even when the same edge writes.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fila_bytes.sv
// Circular byte queue fed by the deserializer's data_ready/ack handshake
// and drained one byte per request by the consumer.
module fila_bytes
  import fila_pkg::*;
#(
  parameter int DEPTH = FILA_DEPTH,
  parameter int WIDTH = FILA_WIDTH
) (
  input  logic                       clk_10KHz,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_ready_in,
  output logic                       ack_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  fila_state_t   r_state;
  fila_state_t   w_state_nxt;
  logic          w_accept;
  logic          w_pop;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_count;
  logic [LW-1:0] w_count_nxt;
  logic          r_ack;
  logic          r_full;
  logic          r_empty;

  // Handshake state register.
  always_ff @(posedge clk_10KHz) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Handshake next state; a byte is taken only from IDLE, and only if the
  // queue was not full before this edge. WAIT_LOW blocks a second write of
  // the same offered byte.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_ready_in && !r_full) begin
          w_accept    = 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK:      w_state_nxt = WAIT_LOW;
      WAIT_LOW: if (!data_ready_in) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  assign w_pop = dequeue_in && !r_empty;

  // Occupancy update; a simultaneous accept and pop leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_pop)      w_count_nxt = r_count + LW'(1);
    else if (!w_accept && w_pop) w_count_nxt = r_count - LW'(1);
  end

  // Pointers, count, ack pulse and flags; flags come from the count so a
  // full queue and an empty queue are never confused by equal pointers.
  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ack   <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_accept) r_wptr <= r_wptr + AW'(1);
      if (w_pop)    r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_ack   <= w_accept;
      r_full  <= (w_count_nxt == LW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  fila_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk     (clk_10KHz),
    .rst     (reset),
    .i_we    (w_accept),
    .i_waddr (r_wptr),
    .i_wdata (data_in),
    .i_re    (w_pop),
    .i_raddr (r_rptr),
    .o_rdata (data_out)
  );

  assign ack_out   = r_ack;
  assign len_out   = r_count;
  assign full_out  = r_full;
  assign empty_out = r_empty;

endmodule

// File: tb/tb_fila_bytes.sv
// Directed vector bench for the fila_bytes byte queue.
module tb_fila_bytes;

  logic       clk_10KHz;
  logic       reset;
  logic [7:0] data_in;
  logic       data_ready_in;
  logic       ack_out;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic [3:0] len_out;
  logic       full_out;
  logic       empty_out;

  fila_bytes #(.DEPTH(8), .WIDTH(8)) dut (
    .clk_10KHz     (clk_10KHz),
    .reset         (reset),
    .data_in       (data_in),
    .data_ready_in (data_ready_in),
    .ack_out       (ack_out),
    .dequeue_in    (dequeue_in),
    .data_out      (data_out),
    .len_out       (len_out),
    .full_out      (full_out),
    .empty_out     (empty_out)
  );

  initial clk_10KHz = 1'b0;
  always #5 clk_10KHz = ~clk_10KHz;

  typedef struct {
    logic       rst;
    logic       dr;
    logic [7:0] din;
    logic       deq;
    logic       ack;
    logic [3:0] len;
    logic       full;
    logic       empty;
    logic [7:0] dout;
  } vec_t;

  vec_t       vq[$];
  int         e_len;
  logic [7:0] e_dout;
  int         n_checks;
  int         n_pass;

  // One cycle: inputs applied before the edge, expected outputs after it.
  function automatic void add(input logic rst, input logic dr, input logic [7:0] din,
                              input logic deq, input logic ack, input int len,
                              input logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.dr = dr; v.din = din; v.deq = deq; v.ack = ack;
    v.len = 4'(len); v.full = (len == 8); v.empty = (len == 0); v.dout = dout;
    vq.push_back(v);
  endfunction

  function automatic void rst_row();
    e_len = 0; e_dout = 8'h00;
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00);
  endfunction

  // Full handshake for one byte: offer (acked), then drop data_ready twice.
  function automatic void push_byte(input logic [7:0] b);
    e_len = e_len + 1;
    add(1'b0, 1'b1, b, 1'b0, 1'b1, e_len, e_dout);
    add(1'b0, 1'b0, b, 1'b0, 1'b0, e_len, e_dout);
    add(1'b0, 1'b0, b, 1'b0, 1'b0, e_len, e_dout);
  endfunction

  function automatic void pop_row(input logic [7:0] b);
    e_len = e_len - 1; e_dout = b;
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, e_len, e_dout);
  endfunction

  initial begin
    int acks;
    n_checks = 0; n_pass = 0;
    reset = 1'b1; data_in = 8'h00; data_ready_in = 1'b0; dequeue_in = 1'b0;

    // Basic accept with data_ready held 3 cycles, then a single pop.
    rst_row();
    add(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1, 8'h00);
    add(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'h00);
    add(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'h00);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h00);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 8'hA5);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 8'hA5);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 8'hA5);  // pop while empty ignored

    // Fill to 8, stalled ninth offer, pop frees space, accept next edge.
    rst_row();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    e_len = 8;
    add(1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 8, 8'h00);
    add(1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 8, 8'h00);
    add(1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 7, 8'h01);
    add(1'b0, 1'b1, 8'h09, 1'b0, 1'b1, 8, 8'h01);
    add(1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 8, 8'h01);
    add(1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 8, 8'h01);

    // Wrap-around: push 8, pop 8, then C3/3C land at the wrapped pointers.
    rst_row();
    for (int i = 0; i < 8; i++) push_byte(8'(8'h11 + i));
    for (int i = 0; i < 8; i++) pop_row(8'(8'h11 + i));
    push_byte(8'hC3);
    push_byte(8'h3C);
    pop_row(8'hC3);
    pop_row(8'h3C);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h3C);

    // Accept and pop on the same edge with 3 queued.
    rst_row();
    push_byte(8'h21); push_byte(8'h22); push_byte(8'h23);
    e_dout = 8'h21;
    add(1'b0, 1'b1, 8'h24, 1'b1, 1'b1, 3, 8'h21);
    add(1'b0, 1'b0, 8'h24, 1'b0, 1'b0, 3, 8'h21);
    add(1'b0, 1'b0, 8'h24, 1'b0, 1'b0, 3, 8'h21);
    pop_row(8'h22); pop_row(8'h23); pop_row(8'h24);

    // One-entry queue: same-edge accept must not write through.
    rst_row();
    push_byte(8'h31);
    e_dout = 8'h31;
    add(1'b0, 1'b1, 8'h32, 1'b1, 1'b1, 1, 8'h31);
    add(1'b0, 1'b0, 8'h32, 1'b0, 1'b0, 1, 8'h31);
    add(1'b0, 1'b0, 8'h32, 1'b0, 1'b0, 1, 8'h31);
    pop_row(8'h32);

    // dequeue held 5 cycles with 2 queued: exactly 2 pops.
    rst_row();
    push_byte(8'h41); push_byte(8'h42);
    pop_row(8'h41); pop_row(8'h42);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h42);

    // Reset in WAIT_LOW with the byte still offered: re-accepted once.
    rst_row();
    add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1, 8'h00);
    add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1, 8'h00);
    add(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 0, 8'h00);
    add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1, 8'h00);
    add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1, 8'h00);
    add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1, 8'h00);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h00);
    e_len = 1; e_dout = 8'h00;
    pop_row(8'h5A);

    foreach (vq[k]) begin
      reset = vq[k].rst; data_ready_in = vq[k].dr;
      data_in = vq[k].din; dequeue_in = vq[k].deq;
      @(posedge clk_10KHz); #1;
      n_checks++;
      if (ack_out === vq[k].ack && len_out === vq[k].len && full_out === vq[k].full &&
          empty_out === vq[k].empty && data_out === vq[k].dout)
        n_pass++;
      else
        $display("FAIL vec%0d: got ack=%b len=%0d full=%b empty=%b dout=%h, want ack=%b len=%0d full=%b empty=%b dout=%h",
                 k, ack_out, len_out, full_out, empty_out, data_out,
                 vq[k].ack, vq[k].len, vq[k].full, vq[k].empty, vq[k].dout);
    end

    // Hand sequence: data_ready held 6 cycles yields a single ack pulse.
    reset = 1'b1; data_ready_in = 1'b0; dequeue_in = 1'b0;
    @(posedge clk_10KHz); #1;
    reset = 1'b0; data_ready_in = 1'b1; data_in = 8'h77;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_10KHz); #1;
      if (ack_out === 1'b1) acks++;
    end
    n_checks++;
    if (acks == 1) n_pass++;
    else $display("FAIL ack_pulse_count: got %0d, want 1", acks);
    n_checks++;
    if (len_out === 4'd1) n_pass++;
    else $display("FAIL held_offer_len: got %0d, want 1", len_out);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
